bcd_countdown: RTL



---
 rtl/bcd_countdown_pkg.sv | 26 ++
 rtl/bcd_digit_dec.sv | 26 ++
 rtl/bcd_countdown.sv | 114 +++++++++++
 3 files changed

// File: rtl/bcd_countdown_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the state encoding, digit limits and the two presets the mode FSM can select.
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ZERO     = 4'd0;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Preset digits packed as {minutes, seconds-tens, seconds-ones}.
    typedef struct packed {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd_time_t;

    localparam bcd_time_t PRESET_30S = {4'd0, 4'd3, 4'd0};
    localparam bcd_time_t PRESET_60S = {4'd1, 4'd0, 4'd0};

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement stage with borrow ripple.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module bcd_digit_dec
    import bcd_countdown_pkg::*;
(
    input  logic [3:0] value,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] next_value,
    output logic       borrow_out
);

    always_comb begin
        next_value = value;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (value != BCD_ZERO) begin
                next_value = value - 4'd1;
            end else begin
                next_value = max;
                borrow_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// M:SS BCD countdown with load, start/pause toggle and completion flag.
// Latency: 1 clk from load/start_pause/tick_1hz to outputs. Backpressure: none, pulses are consumed every cycle.
module bcd_countdown #(
    parameter logic [3:0] SEC_TENS_MAX = 4'd5,
    parameter logic [3:0] DIGIT_MAX    = 4'd9
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       start_pause,
    input  logic [3:0] mode_value_digit0,
    input  logic [3:0] mode_value_digit1,
    input  logic [3:0] mode_value_digit2,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic       running,
    output logic       done
);
    import bcd_countdown_pkg::*;

    state_t     state_q, state_d;
    logic [3:0] digit0_q, digit0_d;
    logic [3:0] digit1_q, digit1_d;
    logic [3:0] digit2_q, digit2_d;
    logic       running_q, running_d;
    logic       done_q, done_d;

    logic [3:0] dec0, dec1, dec2;
    logic       borrow0, borrow1, borrow2;
    logic       cur_zero, dec_zero;

    bcd_digit_dec u_dec0 (
        .value(digit0_q), .max(DIGIT_MAX), .borrow_in(1'b1),
        .next_value(dec0), .borrow_out(borrow0)
    );

    bcd_digit_dec u_dec1 (
        .value(digit1_q), .max(SEC_TENS_MAX), .borrow_in(borrow0),
        .next_value(dec1), .borrow_out(borrow1)
    );

    bcd_digit_dec u_dec2 (
        .value(digit2_q), .max(DIGIT_MAX), .borrow_in(borrow1),
        .next_value(dec2), .borrow_out(borrow2)
    );

    // A borrow rippling out of the minutes digit means the counter is already 0:00.
    assign cur_zero = borrow2;
    assign dec_zero = (dec2 == BCD_ZERO) && (dec1 == BCD_ZERO) && (dec0 == BCD_ZERO);

    always_comb begin
        state_d  = state_q;
        digit0_d = digit0_q;
        digit1_d = digit1_q;
        digit2_d = digit2_q;

        if (load) begin
            digit0_d = (mode_value_digit0 > DIGIT_MAX)    ? DIGIT_MAX    : mode_value_digit0;
            digit1_d = (mode_value_digit1 > SEC_TENS_MAX) ? SEC_TENS_MAX : mode_value_digit1;
            digit2_d = (mode_value_digit2 > DIGIT_MAX)    ? DIGIT_MAX    : mode_value_digit2;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_pause && !cur_zero) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tick_1hz && !cur_zero) begin
                        digit0_d = dec0;
                        digit1_d = dec1;
                        digit2_d = dec2;
                    end
                    // Reaching 0:00 wins over a simultaneous pause press.
                    if (tick_1hz && !cur_zero && dec_zero) state_d = ST_DONE;
                    else if (start_pause)                   state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_pause) state_d = ST_RUN;
                end
                default: state_d = ST_DONE;
            endcase
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q   <= ST_IDLE;
            digit2_q  <= PRESET_30S.d2;
            digit1_q  <= PRESET_30S.d1;
            digit0_q  <= PRESET_30S.d0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit2_q  <= digit2_d;
            digit1_q  <= digit1_d;
            digit0_q  <= digit0_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign digit0  = digit0_q;
    assign digit1  = digit1_q;
    assign digit2  = digit2_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
